// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the fetch slice.
// Holds XLEN, the NOP encoding, the fetch FSM states and the buffer entry.
package riscv_pkg;

    localparam int XLEN  = 32;
    localparam int CNT_W = 3;

    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic {
        RUN   = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/riscv_fetch_fifo.sv
// riscv_fetch_fifo: instruction/PC buffer between memory and core.
// Registered storage, head read straight from the array, flush empties it.
module riscv_fetch_fifo
    import riscv_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_flush,
    input  logic             i_push,
    input  fetch_entry_t     i_data,
    input  logic             i_pop,
    output fetch_entry_t     o_data,
    output logic             o_valid,
    output logic [CNT_W-1:0] o_count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    fetch_entry_t     r_mem [DEPTH];
    logic [AW-1:0]    r_rd;
    logic [AW-1:0]    r_wr;
    logic [CNT_W-1:0] r_cnt;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_full  = (r_cnt == CNT_W'(DEPTH));
    assign w_pop   = i_pop && (r_cnt != '0);
    assign w_push  = i_push && (!w_full || w_pop);
    assign o_valid = (r_cnt != '0);
    assign o_data  = r_mem[r_rd];
    assign o_count = r_cnt;

    // write the incoming entry at the tail
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr] <= i_data;
        end
    end

    // advance pointers and track occupancy
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr <= (r_wr == LAST) ? '0 : r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= (r_rd == LAST) ? '0 : r_rd + 1'b1;
            end
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, w_push}
                           - {{(CNT_W-1){1'b0}}, w_pop};
        end
    end

endmodule

// File: rtl/riscv_fetch.sv
// riscv_fetch: instruction fetch with bounded outstanding requests.
// Define RISCV_FETCH_PERF_EN to add fetch_count/stall_count counters.
module riscv_fetch
    import riscv_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000,
    parameter int              MAX_OUTSTANDING = 2
) (
    input  logic            clk,
    input  logic            rst,
`ifdef RISCV_FETCH_PERF_EN
    output logic [XLEN-1:0] fetch_count,
    output logic [XLEN-1:0] stall_count,
`endif
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic [XLEN-1:0] instruction,
    output logic [XLEN-1:0] instr_pc,
    output logic            instr_valid,
    input  logic            instr_ready
);

    fetch_state_t     r_state;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_rsp_pc;
    logic [CNT_W-1:0] r_inflight;
    logic             r_rsp_ign;

    logic [CNT_W-1:0] w_fifo_cnt;
    logic [CNT_W-1:0] w_inflight_nxt;
    logic [XLEN-1:0]  w_target;
    logic             w_rsp;
    logic             w_req_fire;
    logic             w_out_fire;
    logic             w_push;
    fetch_entry_t     w_head;
    fetch_entry_t     w_entry;
    logic             w_unused;

    assign w_unused = &{1'b0, redirect_pc[1:0]};
    assign w_target = {redirect_pc[XLEN-1:2], 2'b00};

    // in DRAIN r_inflight doubles as the discard count
    assign w_rsp          = imem_rsp_valid && !r_rsp_ign;
    assign imem_req_valid = !rst && (r_state == RUN)
                         && ((r_inflight + w_fifo_cnt)
                             < CNT_W'(MAX_OUTSTANDING));
    assign imem_req_addr  = r_pc;
    assign w_req_fire     = imem_req_valid && imem_req_ready;
    assign w_out_fire     = instr_valid && instr_ready;
    assign w_push         = w_rsp && (r_state == RUN) && !redirect_valid;
    assign w_inflight_nxt = r_inflight
                          + {{(CNT_W-1){1'b0}}, w_req_fire}
                          - {{(CNT_W-1){1'b0}}, w_rsp};

    assign w_entry.pc    = r_rsp_pc;
    assign w_entry.instr = imem_rsp_data;

    riscv_fetch_fifo #(
        .DEPTH (MAX_OUTSTANDING)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (redirect_valid),
        .i_push  (w_push),
        .i_data  (w_entry),
        .i_pop   (w_out_fire),
        .o_data  (w_head),
        .o_valid (instr_valid),
        .o_count (w_fifo_cnt)
    );

    assign instruction = instr_valid ? w_head.instr : NOP;
    assign instr_pc    = instr_valid ? w_head.pc : '0;

    // responses in the cycle right after reset belong to the old stream
    always_ff @(posedge clk) begin
        r_rsp_ign <= rst;
    end

    // fetch FSM: PC, response PC, in-flight/discard count and state
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= RUN;
            r_pc       <= RESET_PC;
            r_rsp_pc   <= RESET_PC;
            r_inflight <= '0;
        end else begin
            r_inflight <= w_inflight_nxt;
            if (redirect_valid) begin
                r_pc     <= w_target;
                r_rsp_pc <= w_target;
                r_state  <= (w_inflight_nxt != '0) ? DRAIN : RUN;
            end else begin
                if (w_req_fire) begin
                    r_pc <= r_pc + 32'd4;
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + 32'd4;
                end
                if ((r_state == DRAIN) && (w_inflight_nxt == '0)) begin
                    r_state <= RUN;
                end
            end
        end
    end

`ifdef RISCV_FETCH_PERF_EN
    logic [XLEN-1:0] r_fetch_cnt;
    logic [XLEN-1:0] r_stall_cnt;

    assign fetch_count = r_fetch_cnt;
    assign stall_count = r_stall_cnt;

    // count output transfers and starved core cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetch_cnt <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_out_fire) begin
                r_fetch_cnt <= r_fetch_cnt + 1'b1;
            end
            if (instr_ready && !instr_valid) begin
                r_stall_cnt <= r_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_fetch.sv
// tb_riscv_fetch: directed bench for riscv_fetch.
// In-order memory model with one-cycle latency and optional hold.
module tb_riscv_fetch;

    localparam logic [31:0] NOP_W = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    int n_chk  = 0;
    int n_fail = 0;

    logic [31:0] req_q[$];
    logic [63:0] out_q[$];
    logic [31:0] mq[$];
    bit          mem_hold = 1'b0;

    riscv_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instruction    (instruction),
        .instr_pc       (instr_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] word(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h00b5_0c33;
            32'h0000_0004: return 32'h40b5_0c33;
            32'h0000_0200: return 32'h00b5_1c33;
            32'h0000_0204: return 32'h00b5_2c33;
            default:       return {a[27:0], 4'h3};
        endcase
    endfunction

    function automatic logic [31:0] rq(input int i);
        if (i < req_q.size()) return req_q[i];
        return 32'hdead_beef;
    endfunction

    function automatic logic [63:0] oq(input int i);
        if (i < out_q.size()) return out_q[i];
        return 64'hdead_beef_dead_beef;
    endfunction

    // memory: sample at negedge, answer one cycle after acceptance
    initial begin
        logic        f;
        logic        r;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            f = imem_req_valid && imem_req_ready;
            a = imem_req_addr;
            r = rst;
            @(posedge clk);
            #2;
            if (r) begin
                mq.delete();
                imem_rsp_valid = 1'b0;
            end else begin
                if (f) mq.push_back(a);
                if (!mem_hold && mq.size() > 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = word(mq.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                end
            end
        end
    end

    // record accepted requests and output transfers
    initial forever begin
        @(negedge clk);
        if (!rst && instr_valid && instr_ready)
            out_q.push_back({instr_pc, instruction});
        if (!rst && imem_req_valid && imem_req_ready)
            req_q.push_back(imem_req_addr);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b0;
        instr_ready    = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_hold       = 1'b0;
        tick(2);
        rst = 1'b0;
        req_q.delete();
        out_q.delete();
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        tick(2);
        @(negedge clk);
        n_chk++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid);
        end
        n_chk++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_instr_valid: got %b expected 0", instr_valid);
        end
        n_chk++;
        if (instruction !== NOP_W) begin
            n_fail++;
            $display("FAIL rst_instr: got %h expected %h", instruction, NOP_W);
        end
        n_chk++;
        if (instr_pc !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_pc: got %h expected 0", instr_pc);
        end
    endtask

    task automatic test_first_fetch();
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        tick(8);
        n_chk++;
        if (rq(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL first_addr0: got %h expected 0", rq(0));
        end
        n_chk++;
        if (rq(1) !== 32'h4) begin
            n_fail++;
            $display("FAIL first_addr1: got %h expected 4", rq(1));
        end
        n_chk++;
        if (oq(0) !== {32'h0, 32'h00b5_0c33}) begin
            n_fail++;
            $display("FAIL first_out0: got %h expected %h",
                     oq(0), {32'h0, 32'h00b5_0c33});
        end
        n_chk++;
        if (oq(1) !== {32'h4, 32'h40b5_0c33}) begin
            n_fail++;
            $display("FAIL first_out1: got %h expected %h",
                     oq(1), {32'h4, 32'h40b5_0c33});
        end
    endtask

    task automatic test_backpressure();
        bit stable_bad;
        int bad;
        stable_bad = 1'b0;
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (instr_valid &&
                {instr_pc, instruction} !== {32'h0, 32'h00b5_0c33})
                stable_bad = 1'b1;
            tick(1);
        end
        n_chk++;
        if (req_q.size() != 2) begin
            n_fail++;
            $display("FAIL bp_req_count: got %0d expected 2", req_q.size());
        end
        n_chk++;
        if (imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid);
        end
        n_chk++;
        if (out_q.size() != 0) begin
            n_fail++;
            $display("FAIL bp_no_out: got %0d expected 0", out_q.size());
        end
        n_chk++;
        if ({instr_valid, instr_pc, instruction} !==
            {1'b1, 32'h0, 32'h00b5_0c33}) begin
            n_fail++;
            $display("FAIL bp_head: got %b %h %h expected 1 0 00b50c33",
                     instr_valid, instr_pc, instruction);
        end
        n_chk++;
        if (stable_bad) begin
            n_fail++;
            $display("FAIL bp_stable: got changing output expected stable");
        end
        instr_ready = 1'b1;
        tick(12);
        n_chk++;
        if (out_q.size() < 4) begin
            n_fail++;
            $display("FAIL bp_resume_count: got %0d expected >=4",
                     out_q.size());
        end
        bad = 0;
        for (int i = 0; i < out_q.size(); i++) begin
            if (out_q[i] !== {32'(4 * i), word(32'(4 * i))}) bad++;
        end
        n_chk++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_resume_seq: got %0d bad entries expected 0",
                     bad);
        end
    endtask

    task automatic test_redirect();
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        mem_hold       = 1'b1;
        tick(4);
        n_chk++;
        if (req_q.size() != 2 || imem_req_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_inflight: got %0d reqs valid %b expected 2 0",
                     req_q.size(), imem_req_valid);
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h103;
        mem_hold       = 1'b0;
        req_q.delete();
        out_q.delete();
        tick(1);
        redirect_valid = 1'b0;
        tick(10);
        n_chk++;
        if (rq(0) !== 32'h100) begin
            n_fail++;
            $display("FAIL rd_addr0: got %h expected 100", rq(0));
        end
        n_chk++;
        if (rq(1) !== 32'h104) begin
            n_fail++;
            $display("FAIL rd_addr1: got %h expected 104", rq(1));
        end
        n_chk++;
        if (oq(0) !== {32'h100, word(32'h100)}) begin
            n_fail++;
            $display("FAIL rd_out0: got %h expected %h",
                     oq(0), {32'h100, word(32'h100)});
        end
    endtask

    task automatic test_redirect_handshake();
        int n52;
        int n51;
        do_reset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        tick(1);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick(6);
        n_chk++;
        if ({instr_valid, instr_pc, instruction} !==
            {1'b1, 32'h200, 32'h00b5_1c33}) begin
            n_fail++;
            $display("FAIL rh_head: got %b %h %h expected 1 200 00b51c33",
                     instr_valid, instr_pc, instruction);
        end
        out_q.delete();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        tick(1);
        redirect_valid = 1'b0;
        tick(10);
        n_chk++;
        if (oq(0) !== {32'h200, 32'h00b5_1c33}) begin
            n_fail++;
            $display("FAIL rh_out0: got %h expected %h",
                     oq(0), {32'h200, 32'h00b5_1c33});
        end
        n_chk++;
        if (oq(1) !== {32'h300, word(32'h300)}) begin
            n_fail++;
            $display("FAIL rh_out1: got %h expected %h",
                     oq(1), {32'h300, word(32'h300)});
        end
        n51 = 0;
        n52 = 0;
        for (int i = 0; i < out_q.size(); i++) begin
            if (out_q[i][31:0] === 32'h00b5_1c33) n51++;
            if (out_q[i][31:0] === 32'h00b5_2c33) n52++;
        end
        n_chk++;
        if (n51 != 1 || n52 != 0) begin
            n_fail++;
            $display("FAIL rh_once: got %0d/%0d expected 1/0", n51, n52);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        instr_ready    = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'hffff_fffe;
        tick(1);
        redirect_valid = 1'b0;
        imem_req_ready = 1'b1;
        tick(8);
        n_chk++;
        if (rq(0) !== 32'hffff_fffc) begin
            n_fail++;
            $display("FAIL wrap_addr0: got %h expected fffffffc", rq(0));
        end
        n_chk++;
        if (rq(1) !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr1: got %h expected 0", rq(1));
        end
        n_chk++;
        if (oq(0) !== {32'hffff_fffc, 32'hffff_ffc3}) begin
            n_fail++;
            $display("FAIL wrap_out0: got %h expected %h",
                     oq(0), {32'hffff_fffc, 32'hffff_ffc3});
        end
        n_chk++;
        if (oq(1) !== {32'h0, 32'h00b5_0c33}) begin
            n_fail++;
            $display("FAIL wrap_out1: got %h expected %h",
                     oq(1), {32'h0, 32'h00b5_0c33});
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        imem_req_ready = 1'b1;
        instr_ready    = 1'b1;
        tick(9);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        req_q.delete();
        out_q.delete();
        @(negedge clk);
        n_chk++;
        if (instr_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_valid: got %b expected 0", instr_valid);
        end
        n_chk++;
        if (instruction !== NOP_W) begin
            n_fail++;
            $display("FAIL mid_instr: got %h expected %h", instruction, NOP_W);
        end
        tick(8);
        n_chk++;
        if (rq(0) !== 32'h0) begin
            n_fail++;
            $display("FAIL mid_addr0: got %h expected 0", rq(0));
        end
        n_chk++;
        if (oq(0) !== {32'h0, 32'h00b5_0c33}) begin
            n_fail++;
            $display("FAIL mid_out0: got %h expected %h",
                     oq(0), {32'h0, 32'h00b5_0c33});
        end
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_backpressure();
        test_redirect();
        test_redirect_handshake();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
